// File: rtl/store_buffer_if.sv
// Core-side store/load port and memory write port of the store buffer.
// The buffer itself connects through the slave modport.
interface store_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic [DATA_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic [DATA_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              mem_hold;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [CNT_W-1:0]  count;
    logic              empty;

    modport master (
        output st_valid, st_addr, st_data, ld_addr, mem_hold,
        input  st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wdata, count, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_addr, mem_hold,
        output st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wdata, count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Four-entry FIFO of pending word stores ahead of the data memory, draining one
// store per cycle and forwarding the youngest matching pending data to loads.
module store_buffer #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic          clock,
    input  logic          reset,
    store_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;

    logic push;
    logic drain;
    logic is_empty;
    logic ready;

    assign ready    = (count_reg < CNT_W'(DEPTH));
    assign is_empty = (count_reg == '0);
    assign push     = bus.st_valid & ready;
    assign drain    = ~is_empty & ~bus.mem_hold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push)
                tail_reg <= tail_reg + 1'b1;
            if (drain)
                head_reg <= head_reg + 1'b1;
            case ({push, drain})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entry storage needs no reset: validity is tracked by head/count alone.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[tail_reg] <= bus.st_addr;
            data_mem[tail_reg] <= bus.st_data;
        end
    end

    // An entry is live when its distance from head is below the count.
    logic [DEPTH-1:0] match;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PTR_W-1:0] age;
            assign age       = PTR_W'(gi) - head_reg;
            assign match[gi] = ({1'b0, age} < count_reg) &&
                               (addr_mem[gi][IDX_W-1:0] == bus.ld_addr[IDX_W-1:0]);
        end
    endgenerate

    // Walk from oldest to youngest so the last hit wins.
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    always_comb begin
        logic [PTR_W-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = head_reg;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_reg + PTR_W'(k);
            if (match[idx]) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end

    assign bus.st_ready  = ready;
    assign bus.empty     = is_empty;
    assign bus.count     = count_reg;
    assign bus.mem_we    = drain;
    assign bus.mem_addr  = is_empty ? '0 : addr_mem[head_reg];
    assign bus.mem_wdata = is_empty ? '0 : data_mem[head_reg];
    assign bus.ld_hit    = hit;
    assign bus.ld_data   = hit_data;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: stimulus queues expected memory writes,
// a negedge monitor pops and checks each write the buffer presents.
module tb_store_buffer;
    logic clock;
    logic reset;

    store_buffer_if #(.DATA_W(32), .DEPTH(4)) bus ();

    store_buffer #(.DATA_W(32), .IDX_W(3), .DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mem_model [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input bit accept);
        check("st_ready", {31'b0, bus.st_ready}, {31'b0, accept});
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        if (accept) exp_q.push_back({a, d});
        $display("push addr=%h data=%h expect_accept=%0d", a, d, accept);
        step();
        bus.st_valid = 1'b0;
    endtask

    // The bench acts as the data memory.
    always @(posedge clock) begin
        if (!reset && bus.mem_we)
            mem_model[bus.mem_addr[2:0]] <= bus.mem_wdata;
    end

    // Scoreboard monitor: every write the buffer presents must be the next expected store.
    always @(negedge clock) begin
        if (!reset && bus.mem_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                $display("drain addr=%h data=%h", bus.mem_addr, bus.mem_wdata);
                check("mem_addr", bus.mem_addr, e[63:32]);
                check("mem_wdata", bus.mem_wdata, e[31:0]);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.ld_addr  = '0;
        bus.mem_hold = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_count", 32'(bus.count), 0);
        check("rst_st_ready", {31'b0, bus.st_ready}, 1);
        check("rst_empty", {31'b0, bus.empty}, 1);
        check("rst_mem_we", {31'b0, bus.mem_we}, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_ld_hit", {31'b0, bus.ld_hit}, 0);
        check("rst_ld_data", bus.ld_data, 0);
        step();

        // Single store into an empty buffer: no bypass, drains next cycle.
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h1C;
        bus.st_data  = 32'h1234;
        bus.ld_addr  = 32'h1C;
        exp_q.push_back({32'h1C, 32'h1234});
        $display("push addr=0000001c data=00001234 expect_accept=1");
        #1;
        check("emptypush_mem_we", {31'b0, bus.mem_we}, 0);
        check("emptypush_no_fwd", {31'b0, bus.ld_hit}, 0);
        step();
        bus.st_valid = 1'b0;
        check("single_mem_we", {31'b0, bus.mem_we}, 1);
        check("single_mem_addr", bus.mem_addr, 32'h1C);
        check("single_mem_wdata", bus.mem_wdata, 32'h1234);
        check("single_fwd_data", bus.ld_data, 32'h1234);
        step();
        check("single_empty", {31'b0, bus.empty}, 1);
        check("single_mem", mem_model[4], 32'h1234);

        // Fill under hold, fifth store refused, then four in-order drains.
        bus.mem_hold = 1'b1;
        push(32'h1, 32'hA1, 1);
        push(32'h2, 32'hA2, 1);
        push(32'h4, 32'hA3, 1);
        push(32'h6, 32'hA4, 1);
        check("full_count", 32'(bus.count), 4);
        check("full_mem_we", {31'b0, bus.mem_we}, 0);
        push(32'h7, 32'hEE, 0);
        check("full_count_after_5th", 32'(bus.count), 4);
        bus.mem_hold = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("drain_count", 32'(bus.count), 32'(4 - k));
            check("drain_mem_we", {31'b0, bus.mem_we}, 1);
            step();
        end
        check("drain_empty", {31'b0, bus.empty}, 1);
        check("drain_mem6", mem_model[6], 32'hA4);

        // Forwarding: youngest alias wins, upper bits ignored, miss reads zero.
        bus.mem_hold = 1'b1;
        push(32'h3, 32'hAA, 1);
        push(32'hB, 32'hBB, 1);
        bus.ld_addr = 32'h3;
        #1;
        check("fwd_hit", {31'b0, bus.ld_hit}, 1);
        check("fwd_data", bus.ld_data, 32'hBB);
        bus.ld_addr = 32'h5;
        #1;
        check("fwd_miss_hit", {31'b0, bus.ld_hit}, 0);
        check("fwd_miss_data", bus.ld_data, 0);
        bus.ld_addr = 32'h13;
        #1;
        check("fwd_alias_data", bus.ld_data, 32'hBB);
        bus.ld_addr  = 32'h3;
        bus.mem_hold = 1'b0;
        step();
        check("fwd_draining_hit", {31'b0, bus.ld_hit}, 1);
        check("fwd_draining_data", bus.ld_data, 32'hBB);
        step();
        check("fwd_gone_hit", {31'b0, bus.ld_hit}, 0);
        check("fwd_mem3", mem_model[3], 32'hBB);

        // Simultaneous push and drain keeps count steady.
        bus.mem_hold = 1'b1;
        push(32'h0, 32'h01, 1);
        push(32'h1, 32'h02, 1);
        bus.mem_hold = 1'b0;
        push(32'h8, 32'h03, 1);
        check("simul_count1", 32'(bus.count), 2);
        push(32'h9, 32'h04, 1);
        check("simul_count2", 32'(bus.count), 2);
        step();
        step();
        check("simul_empty", {31'b0, bus.empty}, 1);
        check("simul_mem0", mem_model[0], 32'h03);
        check("simul_mem1", mem_model[1], 32'h04);

        // Asynchronous reset in the middle of a drain.
        bus.mem_hold = 1'b1;
        push(32'h5, 32'h55, 1);
        push(32'h6, 32'h66, 1);
        bus.ld_addr  = 32'h5;
        bus.mem_hold = 1'b0;
        #1;
        check("pre_rst_mem_we", {31'b0, bus.mem_we}, 1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_count", 32'(bus.count), 0);
        check("midrst_mem_we", {31'b0, bus.mem_we}, 0);
        check("midrst_st_ready", {31'b0, bus.st_ready}, 1);
        check("midrst_ld_hit", {31'b0, bus.ld_hit}, 0);
        check("midrst_mem_addr", bus.mem_addr, 0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("post_rst_empty", {31'b0, bus.empty}, 1);

        check("scoreboard_left", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
